// File: rtl/l1_pkg.sv
// l1_pkg: shared state type, field widths and address-field helpers for the L1 miss controller
`ifndef CORE_IDX_WIDTH
`define CORE_IDX_WIDTH 6
`endif
`ifndef L1_WAY_NUM
`define L1_WAY_NUM 4
`endif
package l1_pkg;
  localparam int L1_ADDR_W = 32;
  localparam int L1_IDX_W = `CORE_IDX_WIDTH;
  localparam int L1_WAY_NUM = `L1_WAY_NUM;
  localparam int L1_LINE_W = 256;
  localparam int L1_WORD_W = 32;
  localparam int OFF_W = $clog2(L1_LINE_W / 8);
  localparam int TAG_W = L1_ADDR_W - L1_IDX_W - OFF_W;
  localparam int WSEL_W = OFF_W - 2;
  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT, REFILL, RESP} l1_state_t;
  function automatic logic [TAG_W-1:0] addr_tag(input logic [L1_ADDR_W-1:0] a);
    return TAG_W'(a >> (L1_IDX_W + OFF_W));
  endfunction
  function automatic logic [L1_IDX_W-1:0] addr_idx(input logic [L1_ADDR_W-1:0] a);
    return L1_IDX_W'(a >> OFF_W);
  endfunction
  function automatic logic [WSEL_W-1:0] addr_woff(input logic [L1_ADDR_W-1:0] a);
    return WSEL_W'(a >> 2);
  endfunction
endpackage

// File: rtl/l1_miss_ctrl_perf_cnt.sv
// l1_perf_cnt: saturating event counter
// ports: clk, rst (async, active-high), inc (count strobe), cnt (current count, sticks at all-ones)
module l1_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/l1_miss_ctrl.sv
// l1_miss_ctrl: L1 read-path sequencer (lookup, miss fetch, refill, response, perf counters)
// ports: core_req_*/core_resp_* core side; arr_* tag/data array; lru_* LRU/hit block;
//        mem_* line fetch; hit_cnt/miss_cnt counters; err_unexp_resp sticky stray-response flag
module l1_miss_ctrl
  import l1_pkg::*;
#(
  parameter int ADDR_W = L1_ADDR_W,
  parameter int IDX_W = L1_IDX_W,
  parameter int WAY_NUM = L1_WAY_NUM,
  parameter int LINE_W = L1_LINE_W,
  parameter int WORD_W = L1_WORD_W,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               core_req_val,
  input  logic [ADDR_W-1:0]  core_req_addr,
  output logic               core_req_ack,
  output logic               core_resp_val,
  output logic [WORD_W-1:0]  core_resp_data,
  output logic               arr_rd_en,
  output logic [IDX_W-1:0]   arr_idx,
  input  logic [WORD_W-1:0]  arr_hit_data,
  output logic               lru_req,
  output logic [IDX_W-1:0]   lru_idx,
  input  logic               lru_hit,
  input  logic [WAY_NUM-1:0] lru_way_vect,
  output logic               arr_we,
  output logic [WAY_NUM-1:0] arr_we_way,
  output logic [TAG_W-1:0]   arr_wr_tag,
  output logic [LINE_W-1:0]  arr_wr_line,
  output logic               mem_req_val,
  input  logic               mem_req_ack,
  output logic [ADDR_W-1:0]  mem_req_addr,
  input  logic               mem_resp_val,
  input  logic [LINE_W-1:0]  mem_resp_data,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt,
  output logic               err_unexp_resp
);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);
  l1_state_t state, nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [WAY_NUM-1:0] victim_q;
  logic [LINE_W-1:0] line_q;
  logic [WORD_W-1:0] resp_q;
  logic hit_inc, miss_inc, fill;
  assign hit_inc = state == LOOKUP && lru_hit;
  assign miss_inc = state == LOOKUP && !lru_hit;
  assign fill = state == MISS_WAIT && mem_resp_val;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      addr_q <= '0;
      victim_q <= '0;
      line_q <= '0;
      resp_q <= '0;
      err_unexp_resp <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && core_req_val) addr_q <= core_req_addr;
      if (hit_inc) resp_q <= arr_hit_data;
      if (miss_inc) victim_q <= lru_way_vect;
      if (fill) begin
        line_q <= mem_resp_data;
        resp_q <= mem_resp_data[int'(addr_woff(addr_q))*WORD_W +: WORD_W];
      end
      if (mem_resp_val && state != MISS_WAIT) err_unexp_resp <= 1'b1;
    end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = core_req_val ? LOOKUP : IDLE;
      LOOKUP:    nxt = lru_hit ? RESP : MISS_REQ;
      MISS_REQ:  nxt = mem_req_ack ? MISS_WAIT : MISS_REQ;
      MISS_WAIT: nxt = mem_resp_val ? REFILL : MISS_WAIT;
      REFILL:    nxt = RESP;
      RESP:      nxt = IDLE;
      default:   nxt = IDLE;
    endcase
    core_req_ack = state == IDLE && core_req_val;
    arr_rd_en = core_req_ack;
    arr_idx = state == IDLE ? addr_idx(core_req_addr) : addr_idx(addr_q);
    lru_req = state == LOOKUP;
    lru_idx = addr_idx(addr_q);
    mem_req_val = state == MISS_REQ;
    mem_req_addr = addr_q & ~OFF_MASK;
    arr_we = state == REFILL;
    arr_we_way = victim_q;
    arr_wr_tag = addr_tag(addr_q);
    arr_wr_line = line_q;
    core_resp_val = state == RESP;
    core_resp_data = resp_q;
  end
  l1_perf_cnt #(.W(CNT_W)) u_hit_cnt (.clk(clk), .rst(rst), .inc(hit_inc), .cnt(hit_cnt));
  l1_perf_cnt #(.W(CNT_W)) u_miss_cnt (.clk(clk), .rst(rst), .inc(miss_inc), .cnt(miss_cnt));
endmodule

// File: tb/tb_l1_miss_ctrl.sv
// tb_l1_miss_ctrl: directed self-checking bench for l1_miss_ctrl with a transaction-level model
module tb_l1_miss_ctrl;
  localparam int CW = 4;
  logic clk = 0, rst = 1;
  logic core_req_val = 0;
  logic [31:0] core_req_addr = '0;
  logic core_req_ack, core_resp_val;
  logic [31:0] core_resp_data;
  logic arr_rd_en;
  logic [5:0] arr_idx, lru_idx;
  logic [31:0] arr_hit_data = '0;
  logic lru_req;
  logic lru_hit = 0;
  logic [3:0] lru_way_vect = '0;
  logic arr_we;
  logic [3:0] arr_we_way;
  logic [20:0] arr_wr_tag;
  logic [255:0] arr_wr_line;
  logic mem_req_val;
  logic mem_req_ack = 0;
  logic [31:0] mem_req_addr;
  logic mem_resp_val = 0;
  logic [255:0] mem_resp_data = '0;
  logic [CW-1:0] hit_cnt, miss_cnt;
  logic err_unexp_resp;

  l1_miss_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .core_req_val(core_req_val), .core_req_addr(core_req_addr),
    .core_req_ack(core_req_ack), .core_resp_val(core_resp_val), .core_resp_data(core_resp_data),
    .arr_rd_en(arr_rd_en), .arr_idx(arr_idx), .arr_hit_data(arr_hit_data), .lru_req(lru_req),
    .lru_idx(lru_idx), .lru_hit(lru_hit), .lru_way_vect(lru_way_vect), .arr_we(arr_we),
    .arr_we_way(arr_we_way), .arr_wr_tag(arr_wr_tag), .arr_wr_line(arr_wr_line),
    .mem_req_val(mem_req_val), .mem_req_ack(mem_req_ack), .mem_req_addr(mem_req_addr),
    .mem_resp_val(mem_resp_val), .mem_resp_data(mem_resp_data), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt), .err_unexp_resp(err_unexp_resp)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int n_hit = 0, n_miss = 0;
  bit exp_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_resp, req_addr_seen;
  logic [5:0] we_idx_seen;
  int req_cycles;

  function automatic void check(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endfunction

  function automatic int sat(input int n);
    return n > (1 << CW) - 1 ? (1 << CW) - 1 : n;
  endfunction

  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  always @(posedge clk) begin
    logic [31:0] e;
    #1;
    check("hit_cnt", hit_cnt, sat(n_hit));
    check("miss_cnt", miss_cnt, sat(n_miss));
    check("err_unexp_resp", err_unexp_resp, exp_err);
    if (core_resp_val) begin
      if (exp_q.size() == 0) check("resp_unexpected", core_resp_val, 0);
      else begin
        e = exp_q.pop_front();
        check("resp_data", core_resp_data, e);
      end
    end
  end

  task automatic do_hit(input logic [31:0] a, input logic [31:0] d, input bit hold);
    @(negedge clk);
    core_req_val = 1; core_req_addr = a;
    #1;
    check("hit_ack", core_req_ack, 1);
    check("hit_rd_en", arr_rd_en, 1);
    check("hit_arr_idx", arr_idx, a[10:5]);
    @(negedge clk);
    core_req_val = hold; lru_hit = 1; arr_hit_data = d; lru_way_vect = 4'b0010;
    #1;
    check("hit_lru_req", lru_req, 1);
    check("hit_lru_idx", lru_idx, a[10:5]);
    check("hit_no_ack_lookup", core_req_ack, 0);
    check("hit_no_mem", mem_req_val, 0);
    @(posedge clk);
    n_hit++;
    exp_q.push_back(d);
    @(negedge clk);
    lru_hit = 0; arr_hit_data = '0; lru_way_vect = '0;
    #1;
    check("hit_resp_val", core_resp_val, 1);
    check("hit_no_ack_resp", core_req_ack, 0);
    check("hit_no_we", arr_we, 0);
    last_resp = core_resp_data;
  endtask

  task automatic do_miss(input logic [31:0] a, input logic [3:0] way, input int ack_dly,
                         input logic [255:0] line, input bit stale_on_ack);
    @(negedge clk);
    core_req_val = 1; core_req_addr = a;
    #1;
    check("miss_ack", core_req_ack, 1);
    @(negedge clk);
    core_req_val = 0; lru_hit = 0; lru_way_vect = way;
    #1;
    check("miss_lru_req", lru_req, 1);
    check("miss_lookup_no_mem", mem_req_val, 0);
    @(posedge clk);
    n_miss++;
    req_cycles = 0;
    for (int i = 0; i <= ack_dly; i++) begin
      @(negedge clk);
      lru_way_vect = '0;
      mem_req_ack = i == ack_dly;
      mem_resp_val = stale_on_ack && i == ack_dly;
      mem_resp_data = ~line;
      #1;
      check("miss_req_val", mem_req_val, 1);
      check("miss_req_addr", mem_req_addr, {a[31:5], 5'b0});
      if (i == 0) req_addr_seen = mem_req_addr;
      if (mem_req_val) req_cycles++;
      @(posedge clk);
      if (mem_resp_val) exp_err = 1;
    end
    @(negedge clk);
    mem_req_ack = 0; mem_resp_val = 0; mem_resp_data = '0;
    #1;
    check("miss_wait_no_req", mem_req_val, 0);
    check("miss_wait_no_we", arr_we, 0);
    @(negedge clk);
    mem_resp_val = 1; mem_resp_data = line;
    #1;
    check("miss_arrive_no_we", arr_we, 0);
    @(posedge clk);
    exp_q.push_back(line[a[4:2]*32 +: 32]);
    @(negedge clk);
    mem_resp_val = 0; mem_resp_data = '0;
    #1;
    check("refill_we", arr_we, 1);
    check("refill_way", arr_we_way, way);
    check("refill_idx", arr_idx, a[10:5]);
    check("refill_tag", arr_wr_tag, a[31:11]);
    check("refill_line", arr_wr_line, line);
    check("refill_no_resp", core_resp_val, 0);
    we_idx_seen = arr_idx;
    @(negedge clk);
    #1;
    check("miss_resp_val", core_resp_val, 1);
    check("miss_resp_no_we", arr_we, 0);
    last_resp = core_resp_data;
  endtask

  initial begin
    logic [255:0] l2;
    @(negedge clk);
    #1;
    check("rst_ack", core_req_ack, 0);
    check("rst_resp_val", core_resp_val, 0);
    check("rst_resp_data", core_resp_data, 0);
    check("rst_rd_en", arr_rd_en, 0);
    check("rst_lru_req", lru_req, 0);
    check("rst_we", arr_we, 0);
    check("rst_we_way", arr_we_way, 0);
    check("rst_mem_val", mem_req_val, 0);
    check("rst_mem_addr", mem_req_addr, 0);
    check("rst_wr_tag", arr_wr_tag, 0);
    check("rst_wr_line", arr_wr_line, 0);
    check("rst_lru_idx", lru_idx, 0);
    @(negedge clk);
    rst = 0;
    l2 = make_line(32'h1000_0000);
    l2[63:32] = 32'hDEAD_BEEF;
    do_miss(32'h0000_1044, 4'b0001, 3, l2, 0);
    check("t2_mem_addr", req_addr_seen, 32'h0000_1040);
    check("t2_req_cycles", req_cycles, 4);
    check("t2_we_idx", we_idx_seen, 6'h02);
    check("t2_resp", last_resp, 32'hDEAD_BEEF);
    check("t2_miss_cnt", miss_cnt, 1);
    do_hit(32'h0000_1048, 32'h1234_5678, 0);
    check("t3_resp", last_resp, 32'h1234_5678);
    check("t3_hit_cnt", hit_cnt, 1);
    @(negedge clk);
    mem_resp_val = 1; mem_resp_data = make_line(32'h5000_0000);
    #1;
    check("t4_no_ack", core_req_ack, 0);
    @(posedge clk);
    exp_err = 1;
    @(negedge clk);
    mem_resp_val = 0; mem_resp_data = '0;
    do_hit(32'h0000_00A0, 32'hCAFE_0001, 0);
    check("t4_err_sticky", err_unexp_resp, 1);
    do_miss(32'h0000_3FFC, 4'b0100, 0, make_line(32'h7700_0000), 1);
    check("t4b_resp_word7", last_resp, 32'h7700_0007);
    check("t4b_we_idx", we_idx_seen, 6'h3F);
    @(negedge clk);
    core_req_val = 1; core_req_addr = 32'h0000_2084;
    #1;
    check("t5_ack", core_req_ack, 1);
    @(negedge clk);
    core_req_val = 0; lru_hit = 0; lru_way_vect = 4'b1000;
    @(posedge clk);
    n_miss++;
    @(negedge clk);
    lru_way_vect = '0; mem_req_ack = 1;
    #1;
    check("t5_req_val", mem_req_val, 1);
    @(negedge clk);
    mem_req_ack = 0;
    #1;
    check("t5_wait_no_req", mem_req_val, 0);
    @(negedge clk);
    rst = 1; n_hit = 0; n_miss = 0; exp_err = 0;
    #1;
    check("t5_rst_mem_val", mem_req_val, 0);
    check("t5_rst_hit", hit_cnt, 0);
    check("t5_rst_miss", miss_cnt, 0);
    check("t5_rst_err", err_unexp_resp, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    mem_resp_val = 1; mem_resp_data = make_line(32'h9900_0000);
    #1;
    check("t5_stale_no_we", arr_we, 0);
    @(posedge clk);
    exp_err = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mem_resp_val = 0; mem_resp_data = '0;
      #1;
      check("t5_after_no_we", arr_we, 0);
      check("t5_after_no_resp", core_resp_val, 0);
    end
    for (int i = 0; i < 20; i++) do_hit(32'h0000_4000 + 32'(i * 32), 32'hB000_0000 + 32'(i), 1);
    @(negedge clk);
    core_req_val = 0;
    #1;
    check("t6_hit_sat", hit_cnt, 4'hF);
    check("t6_miss_zero", miss_cnt, 0);
    check("t6_last_resp", last_resp, 32'hB000_0013);
    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
